// File: rtl/mat_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mat_seq_ctrl
// Description : Job sequencer for a matrix engine. Runs X-buffer load, then an
//               ALU pass, then streams N_WORDS result words from SRAM to the
//               host over a valid/ready output port.
//               Optional watchdog: define MAT_SEQ_WDOG_EN to add a stall
//               counter and an ERR state that drives o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_seq_ctrl #(
  parameter int N_WORDS     = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_xload_done,
  input  logic        i_alu_done,
  input  logic        i_ry,
  input  logic [31:0] i_read_data,
  input  logic        i_out_ready,
  output logic        o_input_load_en,
  output logic        o_alu_en,
  output logic        o_cs_n,
  output logic [7:0]  o_rd_addr,
  output logic [31:0] o_out_data,
  output logic        o_out_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  // Parameter sanity checks, evaluated at elaboration only.
  if (N_WORDS < 1 || N_WORDS > 256) begin : g_bad_n_words
    $error("mat_seq_ctrl: N_WORDS must be in 1..256");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
    $error("mat_seq_ctrl: TIMEOUT_CYC must be in 1..1023");
  end

  localparam logic [7:0] c_LAST_ADDR = 8'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CALC    = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_OUT  = 3'd5,
    S_DONE    = 3'd6
`ifdef MAT_SEQ_WDOG_EN
    , S_ERR   = 3'd7
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_rd_addr;
  logic [31:0] r_out_data;
  logic        r_out_valid;

`ifdef MAT_SEQ_WDOG_EN
  localparam logic [9:0] c_WDOG_LAST = 10'(TIMEOUT_CYC - 1);

  logic [9:0] r_wdog;
  logic       w_wdog_cnt_st;
  logic       w_wdog_trip;

  // Only the states that wait on an external handshake are policed.
  assign w_wdog_cnt_st = (r_state == S_LOAD) || (r_state == S_CALC) ||
                         (r_state == S_RD_WAIT);
  // Trip on the cycle in which the TIMEOUT_CYC-th waiting cycle completes.
  assign w_wdog_trip   = w_wdog_cnt_st && (r_wdog == c_WDOG_LAST);

  // Watchdog counter: restarts on every state change, advances while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 10'd0;
    end else if (w_state_nxt != r_state) begin
      r_wdog <= 10'd0;
    end else if (w_wdog_cnt_st && !w_wdog_trip) begin
      r_wdog <= r_wdog + 10'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks every other transition condition.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state != S_IDLE && i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start)      w_state_nxt = S_LOAD;
        S_LOAD:    if (i_xload_done) w_state_nxt = S_CALC;
        S_CALC:    if (i_alu_done)   w_state_nxt = S_RD_REQ;
        S_RD_REQ:                    w_state_nxt = S_RD_WAIT;
        S_RD_WAIT: if (i_ry)         w_state_nxt = S_RD_OUT;
        S_RD_OUT: begin
          if (i_out_ready) begin
            w_state_nxt = (r_rd_addr < c_LAST_ADDR) ? S_RD_REQ : S_DONE;
          end
        end
        S_DONE:                      w_state_nxt = S_IDLE;
`ifdef MAT_SEQ_WDOG_EN
        S_ERR:     if (i_start)      w_state_nxt = S_IDLE;
`endif
        default:                     w_state_nxt = S_IDLE;
      endcase
`ifdef MAT_SEQ_WDOG_EN
      // A stall only trips if the awaited event has not arrived this cycle.
      if (w_wdog_trip && w_state_nxt == r_state) begin
        w_state_nxt = S_ERR;
      end
`endif
    end
  end

  // Readback datapath: address walk, result capture and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr   <= 8'd0;
      r_out_data  <= 32'd0;
      r_out_valid <= 1'b0;
    end else if (w_state_nxt == S_IDLE) begin
      // Any return to IDLE (done, abort, error exit) leaves a clean port.
      r_rd_addr   <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          if (i_alu_done) begin
            r_rd_addr <= 8'd0;
          end
        end
        S_RD_WAIT: begin
          if (i_ry) begin
            r_out_data  <= i_read_data;
            r_out_valid <= 1'b1;
          end
        end
        S_RD_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_rd_addr < c_LAST_ADDR) begin
              r_rd_addr <= r_rd_addr + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control outputs decode directly from the registered state.
  assign o_input_load_en = (r_state == S_LOAD);
  assign o_alu_en        = (r_state == S_CALC);
  assign o_cs_n          = !((r_state == S_RD_REQ) || (r_state == S_RD_WAIT));
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_DONE);
  assign o_rd_addr       = r_rd_addr;
  assign o_out_data      = r_out_data;
  assign o_out_valid     = r_out_valid;
`ifdef MAT_SEQ_WDOG_EN
  assign o_err           = (r_state == S_ERR);
`else
  assign o_err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_seq_ctrl
// Description : Directed self-checking bench for mat_seq_ctrl (N_WORDS=4).
//               Watchdog steps run only when MAT_SEQ_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, abort, xload_done, alu_done, ry, out_ready;
  logic [31:0] read_data;
  logic        input_load_en, alu_en, cs_n, out_valid, busy, done, err;
  logic [7:0]  rd_addr;
  logic [31:0] out_data;

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          t_start;

  mat_seq_ctrl #(
    .N_WORDS     (4),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (start),
    .i_abort         (abort),
    .i_xload_done    (xload_done),
    .i_alu_done      (alu_done),
    .i_ry            (ry),
    .i_read_data     (read_data),
    .i_out_ready     (out_ready),
    .o_input_load_en (input_load_en),
    .o_alu_en        (alu_en),
    .o_cs_n          (cs_n),
    .o_rd_addr       (rd_addr),
    .o_out_data      (out_data),
    .o_out_valid     (out_valid),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read of the addressed word.
  assign read_data = mem[rd_addr];

  // Cycle counter and done-pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_load"},  32'(input_load_en), 32'd0);
    chk({tag, "_alu"},   32'(alu_en),        32'd0);
    chk({tag, "_csn"},   32'(cs_n),          32'd1);
    chk({tag, "_valid"}, 32'(out_valid),     32'd0);
    chk({tag, "_addr"},  32'(rd_addr),       32'd0);
    chk({tag, "_done"},  32'(done),          32'd0);
  endtask

  // From IDLE: start, LOAD for 1+xwait cycles, CALC for 1+await cycles,
  // optionally pulsing start in the first CALC cycle. Ends in RD_REQ.
  task automatic go_to_rdreq(input int xwait, input int await, input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_en", 32'(input_load_en), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < xwait; i++) begin
      step();
      chk("load_hold", 32'(input_load_en), 32'd1);
    end
    xload_done = 1'b1;
    step();
    xload_done = 1'b0;
    chk("calc_alu_en", 32'(alu_en), 32'd1);
    chk("calc_load_off", 32'(input_load_en), 32'd0);
    for (int i = 0; i < await; i++) begin
      start = poke && (i == 0);
      step();
      start = 1'b0;
      chk("calc_hold", 32'(alu_en), 32'd1);
    end
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("rdreq_alu_off", 32'(alu_en), 32'd0);
  endtask

  // Stream all 4 words; word stall_word is held for stall_cyc cycles with
  // out_ready low. Ends in DONE.
  task automatic run_words(input int stall_word, input int stall_cyc);
    for (int k = 0; k < 4; k++) begin
      chk("rdreq_csn", 32'(cs_n), 32'd0);
      chk("rdreq_addr", 32'(rd_addr), 32'(k));
      chk("rdreq_valid", 32'(out_valid), 32'd0);
      step();
      chk("rdwait_csn", 32'(cs_n), 32'd0);
      if (k == stall_word) out_ready = 1'b0;
      step();
      chk("rdout_valid", 32'(out_valid), 32'd1);
      chk("rdout_data", out_data, mem[k]);
      chk("rdout_csn", 32'(cs_n), 32'd1);
      if (k == stall_word) begin
        for (int i = 1; i < stall_cyc; i++) begin
          step();
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", out_data, mem[k]);
          chk("stall_addr", 32'(rd_addr), 32'(k));
          chk("stall_csn", 32'(cs_n), 32'd1);
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic finish_job(input int exp_done_cnt);
    step();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_addr", 32'(rd_addr), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done_cnt));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0BAD_0000 + 32'(i);
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h0000_0001;
    mem[2] = 32'hFFFF_FFFF;
    mem[3] = 32'h8000_0000;
    start = 0; abort = 0; xload_done = 0; alu_done = 0; ry = 0; out_ready = 0;

    // Reset values.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst_data", out_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Handshakes in IDLE do nothing.
    xload_done = 1; alu_done = 1; ry = 1; out_ready = 1;
    step();
    xload_done = 0; alu_done = 0;
    chk_idle("idle_ignore");

    // Nominal job: LOAD 4 cycles, CALC 10 cycles, no backpressure.
    go_to_rdreq(3, 9, 1'b0);
    run_words(-1, 0);
    finish_job(1);

    // Backpressure on word 2 with an ignored start during CALC.
    mem[0] = 32'h1111_2222;
    mem[1] = 32'h3333_4444;
    mem[2] = 32'h5555_6666;
    mem[3] = 32'h7777_8888;
    go_to_rdreq(0, 3, 1'b1);
    run_words(2, 5);
    finish_job(2);
    step();
    chk("no_queued_start", 32'(busy), 32'd0);

    // Abort coinciding with ALU_done.
    start = 1; step(); start = 0;
    xload_done = 1; step(); xload_done = 0;
    chk("abort_pre_alu", 32'(alu_en), 32'd1);
    alu_done = 1; abort = 1;
    step();
    alu_done = 0; abort = 0;
    chk_idle("abort_calc");
    step();
    chk("abort_calc_cnt", 32'(done_cnt), 32'd2);

    // Abort coinciding with acceptance of word 1.
    go_to_rdreq(0, 0, 1'b0);
    step(); step(); step();
    chk("abort_rd_addr1", 32'(rd_addr), 32'd1);
    step(); step();
    chk("abort_rd_valid", 32'(out_valid), 32'd1);
    abort = 1;
    step();
    abort = 0;
    chk_idle("abort_rdout");
    step();
    chk("abort_rd_cnt", 32'(done_cnt), 32'd2);

    // Asynchronous reset while waiting on ry.
    ry = 0;
    go_to_rdreq(0, 0, 1'b0);
    step(); step();
    chk("wait_csn", 32'(cs_n), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_no_restart", 32'(busy), 32'd0);

    // Full job after reset, minimum latency 3 + 3*4 = 15 cycles.
    ry = 1;
    t_start = cyc;
    go_to_rdreq(0, 0, 1'b0);
    run_words(-1, 0);
    chk("min_latency", 32'(cyc - t_start), 32'd15);
    finish_job(3);

`ifdef MAT_SEQ_WDOG_EN
    // Watchdog: LOAD stalls for 20 cycles, then ERR; start recovers.
    start = 1; step(); start = 0;
    for (int i = 1; i < 20; i++) step();
    chk("wd_load_hold", 32'(input_load_en), 32'd1);
    chk("wd_no_err_yet", 32'(err), 32'd0);
    step();
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_busy", 32'(busy), 32'd1);
    chk("wd_load_off", 32'(input_load_en), 32'd0);
    start = 1;
    step();
    chk("wd_err_clr", 32'(err), 32'd0);
    chk("wd_idle", 32'(busy), 32'd0);
    step();
    start = 0;
    chk("wd_reload", 32'(input_load_en), 32'd1);
    abort = 1; step(); abort = 0;
    chk_idle("wd_abort");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
